// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the two-port block-RAM arbiter.
package mem_port_arbiter_pkg;

    localparam int NUM_PORTS = 2;
    localparam int LANES     = 4;
    localparam int LANE_W    = 8;
    localparam int WORD_W    = LANES * LANE_W;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_e;

    // Everything the response stage needs to know about the access granted
    // in the previous cycle.
    typedef struct packed {
        logic       valid;
        logic       id;
        logic [1:0] size;
        logic       uns;
        logic [1:0] off;
        logic       err;
        logic       we;
    } rsp_meta_t;

    // Pull the byte/half at 'off' out of a RAM word and extend it to a full word.
    function automatic logic [WORD_W-1:0] load_extend(input logic [WORD_W-1:0] word,
                                                      input logic [1:0]        size,
                                                      input logic              uns,
                                                      input logic [1:0]        off);
        logic [WORD_W-1:0] shifted;
        logic [WORD_W-1:0] result;
        shifted = word >> {off, 3'b000};
        case (size)
            SZ_B:    result = {{24{shifted[7] & ~uns}}, shifted[7:0]};
            SZ_H:    result = {{16{shifted[15] & ~uns}}, shifted[15:0]};
            default: result = shifted;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle for both requesters of the RAM port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_we;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][1:0]        req_size;
    logic [1:0]             req_unsigned;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0]             rsp_valid;
    logic [1:0][DATA_W-1:0] rsp_rdata;
    logic [1:0]             rsp_err;

    // Requesters drive requests and consume responses.
    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // The arbiter grants requests and returns responses.
    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// Request-side lane logic: alignment check, byte enables and lane-replicated
// store data for one access.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]        off,
    input  logic [1:0]        size,
    input  logic              we,
    input  logic [WORD_W-1:0] wdata,
    output logic [LANES-1:0]  be,
    output logic [WORD_W-1:0] lane_wdata,
    output logic              err
);

    // Misaligned half/word or the reserved size code makes the access an error.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        err = 1'b0;
        case (size)
            SZ_B:    err = 1'b0;
            SZ_H:    err = off[0];
            SZ_W:    err = (off != 2'b00);
            default: err = 1'b1;
        endcase
    end

    // Legal stores enable the addressed lanes; data is replicated so the
    // enables alone pick what lands in the RAM.
    always_comb begin
        be         = '0;
        lane_wdata = '0;
        if (we && !err) begin
            case (size)
                SZ_B: begin
                    be         = 4'b0001 << off;
                    lane_wdata = {4{wdata[7:0]}};
                end
                SZ_H: begin
                    be         = 4'b0011 << off;
                    lane_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    be         = 4'b1111;
                    lane_wdata = wdata;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single read/write port of the block RAM.
// Grants one request per cycle, drives the RAM, and returns extended load
// data or a store acknowledge to the winner exactly one cycle later.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [LANES-1:0]     mem_be,
    output logic                 mem_we,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata
);

    logic       last_q, last_d;
    rsp_meta_t  meta_q, meta_d;
    logic [1:0] grant;
    logic       sel;

    logic [LANES-1:0]  al_be;
    logic [WORD_W-1:0] al_wdata;
    logic              al_err;

    // Grant: port 0 on conflict unless round-robin and port 0 won last;
    // nothing is granted while reset is held so no store can slip out.
    always_comb begin
        grant = 2'b00;
        if (rst_n) begin
            if (bus.req_valid == 2'b11) begin
                grant = (RR_MODE != 0 && !last_q) ? 2'b10 : 2'b01;
            end else begin
                grant = bus.req_valid;
            end
        end
    end

    assign sel           = grant[1];
    assign bus.req_ready = grant;

    mem_lane_align u_align (
        .off        (bus.req_addr[sel][1:0]),
        .size       (bus.req_size[sel]),
        .we         (bus.req_we[sel]),
        .wdata      (bus.req_wdata[sel]),
        .be         (al_be),
        .lane_wdata (al_wdata),
        .err        (al_err)
    );

    // RAM drive: granted access goes out, idle cycles present all zeros.
    always_comb begin
        mem_addr  = '0;
        mem_be    = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (grant != 2'b00) begin
            mem_addr  = bus.req_addr[sel];
            mem_be    = al_be;
            mem_we    = bus.req_we[sel] & ~al_err;
            mem_wdata = al_wdata;
        end
    end

    // Next-state for the last-grant pointer and the response register.
    always_comb begin
        last_d       = (grant != 2'b00) ? sel : last_q;
        meta_d       = '0;
        meta_d.valid = (grant != 2'b00);
        meta_d.id    = sel;
        meta_d.size  = bus.req_size[sel];
        meta_d.uns   = bus.req_unsigned[sel];
        meta_d.off   = bus.req_addr[sel][1:0];
        meta_d.err   = al_err;
        meta_d.we    = bus.req_we[sel];
    end

    // Pointer starts at port 1 so port 0 wins the first conflict; reset
    // drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
            meta_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            last_q <= last_d;
            meta_q <= meta_d;
        end
    end

    // Response: route to the port granted last cycle; stores and errors
    // return zero data.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_err   = '0;
        bus.rsp_rdata = '0;
        if (meta_q.valid) begin
            bus.rsp_valid[meta_q.id] = 1'b1;
            bus.rsp_err[meta_q.id]   = meta_q.err;
            if (!meta_q.err && !meta_q.we) begin
                bus.rsp_rdata[meta_q.id] = load_extend(mem_rdata, meta_q.size,
                                                       meta_q.uns, meta_q.off);
            end
        end
    end

endmodule
